// File: rtl/new_sys_pkg.sv
// Shared constants for the 5x5 pixel frame link: slot/frame timing derivation
// and the ten digit templates, imported by both transmitter and receiver.
package new_sys_pkg;

   localparam int PIX_N = 25;
   localparam logic [3:0] DIGIT_NONE = 4'd11;

   function automatic int slot_len(input int tt);
      return 2 * (tt + 1);
   endfunction

   function automatic int frame_len(input int tt);
      return 28 * slot_len(tt);
   endfunction

   // Emission sits in the guard window, a few cycles after the last line closes.
   function automatic int emit_at(input int tt);
      return 27 * slot_len(tt) + tt + 1;
   endfunction

   // MSB of each literal is the first pixel of the top row.
   localparam logic [PIX_N-1:0] DIGIT_TPL [0:9] = '{
      25'b00100_01010_01010_01010_00100,
      25'b00100_01100_00100_00100_01110,
      25'b01100_10010_00100_01000_11111,
      25'b01100_00010_00100_00010_01100,
      25'b00010_00110_01010_11111_00010,
      25'b01110_01000_01100_00010_01100,
      25'b00100_01000_01100_01010_00100,
      25'b11110_00010_00100_01000_01000,
      25'b00100_01010_00100_01010_00100,
      25'b00100_01010_00110_00010_00010
   };

endpackage

// File: rtl/digit_matcher.sv
// Combinational exact-match of a 25-bit pattern against the ten digit templates.
module digit_matcher
   import new_sys_pkg::*;
(
   input  logic [PIX_N-1:0] i_acc,
   output logic [3:0]       o_digit,
   output logic             o_match
);

   logic [9:0] w_hit;

   genvar gi;
   generate
      for (gi = 0; gi < 10; gi++) begin : g_tpl
         assign w_hit[gi] = (i_acc == DIGIT_TPL[gi]);
      end
   endgenerate

   // Templates are distinct, so at most one hit bit is ever set.
   always_comb begin
      o_digit = DIGIT_NONE;
      o_match = 1'b0;
      for (int d = 0; d < 10; d++) begin
         if (w_hit[d]) begin
            o_digit = 4'(d);
            o_match = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pixel_frame_receiver.sv
// Rebuilds the 25-pixel frame from slot-multiplexed pulse lines, flags slot and
// overlap violations, and presents the frame plus matched digit once per frame.
module pixel_frame_receiver
   import new_sys_pkg::*;
#(
   parameter int TT = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_N-1:0] pix_in,
   output logic             frame_valid,
   output logic [PIX_N-1:0] pattern,
   output logic [3:0]       digit,
   output logic             match,
   output logic             frame_err
);

   localparam int SLOT    = slot_len(TT);
   localparam int FRAME   = frame_len(TT);
   localparam int EMIT_AT = emit_at(TT);
   localparam int FCNT_W  = $clog2(FRAME);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME - 1);
   localparam logic [FCNT_W-1:0] FCNT_EMIT = FCNT_W'(EMIT_AT);

   logic [FCNT_W-1:0] r_fcnt;
   logic [PIX_N-1:0]  r_acc;
   logic              r_err;
   logic              r_valid;
   logic [PIX_N-1:0]  r_pattern;
   logic [3:0]        r_digit;
   logic              r_match;
   logic              r_frame_err;

   logic [PIX_N-1:0]  w_in_win;
   logic [PIX_N-1:0]  w_hit;
   logic              w_stray;
   logic              w_overlap;
   logic              w_viol;
   logic [3:0]        w_digit;
   logic              w_match;

   genvar gi;
   generate
      for (gi = 0; gi < PIX_N; gi++) begin : g_win
         localparam logic [FCNT_W-1:0] LO = FCNT_W'(SLOT * (gi + 1) + TT + 2);
         localparam logic [FCNT_W-1:0] HI = FCNT_W'(SLOT * (gi + 2) + TT + 1);
         assign w_in_win[gi] = (r_fcnt >= LO) && (r_fcnt <= HI);
      end
   endgenerate

   assign w_hit     = pix_in & w_in_win;
   assign w_stray   = |(pix_in & ~w_in_win);
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign w_overlap = |(pix_in & (pix_in - 25'd1));
   assign w_viol    = w_stray | w_overlap;

   digit_matcher u_matcher (
      .i_acc   (r_acc),
      .o_digit (w_digit),
      .o_match (w_match)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fcnt      <= '0;
         r_acc       <= '0;
         r_err       <= 1'b0;
         r_valid     <= 1'b0;
         r_pattern   <= '0;
         r_digit     <= DIGIT_NONE;
         r_match     <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_fcnt  <= (r_fcnt == FCNT_LAST) ? '0 : r_fcnt + 1'b1;
         r_valid <= 1'b0;
         if (r_fcnt == FCNT_EMIT) begin
            r_pattern   <= r_acc;
            r_frame_err <= r_err;
            r_digit     <= w_digit;
            r_match     <= w_match;
            r_valid     <= 1'b1;
            // This cycle's sample belongs to the next frame.
            r_acc       <= w_hit;
            r_err       <= w_viol;
         end else begin
            r_acc <= r_acc | w_hit;
            r_err <= r_err | w_viol;
         end
      end
   end

   assign frame_valid = r_valid;
   assign pattern     = r_pattern;
   assign digit       = r_digit;
   assign match       = r_match;
   assign frame_err   = r_frame_err;

endmodule
